// File: rtl/ecl_byp_pkg.sv
// Shared definitions for the ECL register-bypass tag pipe.
// Optional feature macro: ECL_BYP_W2_EN (adds a W2 stage for late load return).
package ecl_byp_pkg;

    localparam int TAG_W = 7;
    localparam int REG_W = 5;

    localparam logic [REG_W-1:0] G0_REG = '0;

`ifdef ECL_BYP_W2_EN
    localparam int SEL_W      = 5;
    localparam int BYP_SEL_E  = 0;
    localparam int BYP_SEL_M  = 1;
    localparam int BYP_SEL_W  = 2;
    localparam int BYP_SEL_W2 = 3;
    localparam int BYP_SEL_RF = 4;
`else
    localparam int SEL_W      = 4;
    localparam int BYP_SEL_E  = 0;
    localparam int BYP_SEL_M  = 1;
    localparam int BYP_SEL_W  = 2;
    localparam int BYP_SEL_RF = 3;
`endif

    // One in-flight destination: valid bit plus full {tid, reg} tag.
    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] rd;
    } pipe_ent_t;

    // A source hits an entry only on a full-tag match against a valid producer.
    function automatic logic tag_hit(input pipe_ent_t ent, input logic [TAG_W-1:0] rs);
        return ent.vld && (ent.rd == rs);
    endfunction

endpackage

// File: rtl/ecl_byp_src_sel.sv
// Bypass select for one source operand: compares the source tag against every
// in-flight destination and picks the youngest producer, else the register file.
// Optional feature macro: ECL_BYP_W2_EN.
module ecl_byp_src_sel
    import ecl_byp_pkg::*;
(
    input  logic [TAG_W-1:0] rs,
    input  pipe_ent_t        ent_e,
    input  pipe_ent_t        ent_m,
    input  pipe_ent_t        ent_w,
`ifdef ECL_BYP_W2_EN
    input  pipe_ent_t        ent_w2,
`endif
    output logic [SEL_W-1:0] sel
);

    // Priority chain from youngest to oldest keeps the select strictly one-hot.
    always_comb begin
        sel = '0;
        if (tag_hit(ent_e, rs)) begin
            sel[BYP_SEL_E] = 1'b1;
        end else if (tag_hit(ent_m, rs)) begin
            sel[BYP_SEL_M] = 1'b1;
        end else if (tag_hit(ent_w, rs)) begin
            sel[BYP_SEL_W] = 1'b1;
`ifdef ECL_BYP_W2_EN
        end else if (tag_hit(ent_w2, rs)) begin
            sel[BYP_SEL_W2] = 1'b1;
`endif
        end else begin
            sel[BYP_SEL_RF] = 1'b1;
        end
    end

endmodule

// File: rtl/sparc_exu_ecl_byp_tag_pipe.sv
// Producer side of the ECL bypass compare path: carries destination tags down
// E/M/W, generates one-hot bypass selects for three D-stage sources, and issues
// the register-file write request from the last stage.
// Optional feature macro: ECL_BYP_W2_EN (W2 stage, writes issued from W2).
module sparc_exu_ecl_byp_tag_pipe
    import ecl_byp_pkg::*;
(
    input  logic             rclk,
    input  logic             arst_l,
    input  logic [TAG_W-1:0] dec_rd_d,
    input  logic             dec_wen_d,
    input  logic [TAG_W-1:0] dec_rs1_d,
    input  logic [TAG_W-1:0] dec_rs2_d,
    input  logic [TAG_W-1:0] dec_rs3_d,
    input  logic             ecl_stall_d,
    input  logic             ecl_flush_e,
    output logic [SEL_W-1:0] byp_rs1_sel,
    output logic [SEL_W-1:0] byp_rs2_sel,
    output logic [SEL_W-1:0] byp_rs3_sel,
    output logic             ecl_rf_wen_w,
    output logic [TAG_W-1:0] ecl_rf_rd_w
);

    pipe_ent_t ent_e;
    pipe_ent_t ent_m;
    pipe_ent_t ent_w;
`ifdef ECL_BYP_W2_EN
    pipe_ent_t ent_w2;
`endif

    logic qual_d;

    // Writes to %g0 never become valid, so a %g0 source can never be bypassed.
    assign qual_d = dec_wen_d && (dec_rd_d[REG_W-1:0] != G0_REG);

    // Pipe advance: stall bubbles only E, flush kills only the E entry, M/W always move.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            ent_e  <= '0;
            ent_m  <= '0;
            ent_w  <= '0;
`ifdef ECL_BYP_W2_EN
            ent_w2 <= '0;
`endif
        end else begin
            ent_e.vld <= qual_d && !ecl_stall_d;
            ent_e.rd  <= dec_rd_d;
            ent_m.vld <= ent_e.vld && !ecl_flush_e;
            ent_m.rd  <= ent_e.rd;
            ent_w     <= ent_m;
`ifdef ECL_BYP_W2_EN
            ent_w2    <= ent_w;
`endif
        end
    end

`ifdef ECL_BYP_W2_EN
    assign ecl_rf_wen_w = ent_w2.vld;
    assign ecl_rf_rd_w  = ent_w2.rd;
`else
    assign ecl_rf_wen_w = ent_w.vld;
    assign ecl_rf_rd_w  = ent_w.rd;
`endif

    ecl_byp_src_sel u_rs1_sel (
        .rs     (dec_rs1_d),
        .ent_e  (ent_e),
        .ent_m  (ent_m),
        .ent_w  (ent_w),
`ifdef ECL_BYP_W2_EN
        .ent_w2 (ent_w2),
`endif
        .sel    (byp_rs1_sel)
    );

    ecl_byp_src_sel u_rs2_sel (
        .rs     (dec_rs2_d),
        .ent_e  (ent_e),
        .ent_m  (ent_m),
        .ent_w  (ent_w),
`ifdef ECL_BYP_W2_EN
        .ent_w2 (ent_w2),
`endif
        .sel    (byp_rs2_sel)
    );

    ecl_byp_src_sel u_rs3_sel (
        .rs     (dec_rs3_d),
        .ent_e  (ent_e),
        .ent_m  (ent_m),
        .ent_w  (ent_w),
`ifdef ECL_BYP_W2_EN
        .ent_w2 (ent_w2),
`endif
        .sel    (byp_rs3_sel)
    );

endmodule

// File: tb/tb_sparc_exu_ecl_byp_tag_pipe.sv
// Directed bench for the ECL bypass tag pipe: reset, back-to-back producers,
// %g0 and thread isolation, flush, stall and writeback latency.
// Honours ECL_BYP_W2_EN for select width and write latency.
module tb_sparc_exu_ecl_byp_tag_pipe;
    import ecl_byp_pkg::*;

`ifdef ECL_BYP_W2_EN
    localparam logic [SEL_W-1:0] S_E  = 5'b00001;
    localparam logic [SEL_W-1:0] S_M  = 5'b00010;
    localparam logic [SEL_W-1:0] S_W  = 5'b00100;
    localparam logic [SEL_W-1:0] S_W2 = 5'b01000;
    localparam logic [SEL_W-1:0] S_RF = 5'b10000;
    localparam int               WLAT = 4;
`else
    localparam logic [SEL_W-1:0] S_E  = 4'b0001;
    localparam logic [SEL_W-1:0] S_M  = 4'b0010;
    localparam logic [SEL_W-1:0] S_W  = 4'b0100;
    localparam logic [SEL_W-1:0] S_RF = 4'b1000;
    localparam int               WLAT = 3;
`endif

    logic             rclk;
    logic             arst_l;
    logic [TAG_W-1:0] dec_rd_d;
    logic             dec_wen_d;
    logic [TAG_W-1:0] dec_rs1_d;
    logic [TAG_W-1:0] dec_rs2_d;
    logic [TAG_W-1:0] dec_rs3_d;
    logic             ecl_stall_d;
    logic             ecl_flush_e;
    logic [SEL_W-1:0] byp_rs1_sel;
    logic [SEL_W-1:0] byp_rs2_sel;
    logic [SEL_W-1:0] byp_rs3_sel;
    logic             ecl_rf_wen_w;
    logic [TAG_W-1:0] ecl_rf_rd_w;

    int checks   = 0;
    int failures = 0;

    sparc_exu_ecl_byp_tag_pipe dut (
        .rclk         (rclk),
        .arst_l       (arst_l),
        .dec_rd_d     (dec_rd_d),
        .dec_wen_d    (dec_wen_d),
        .dec_rs1_d    (dec_rs1_d),
        .dec_rs2_d    (dec_rs2_d),
        .dec_rs3_d    (dec_rs3_d),
        .ecl_stall_d  (ecl_stall_d),
        .ecl_flush_e  (ecl_flush_e),
        .byp_rs1_sel  (byp_rs1_sel),
        .byp_rs2_sel  (byp_rs2_sel),
        .byp_rs3_sel  (byp_rs3_sel),
        .ecl_rf_wen_w (ecl_rf_wen_w),
        .ecl_rf_rd_w  (ecl_rf_rd_w)
    );

    // Free-running core clock.
    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    // Drive one D-stage cycle right after the falling edge, then let it settle.
    task automatic applyStimulus(input logic wen, input logic [TAG_W-1:0] rd,
                                 input logic stall, input logic flush,
                                 input logic [TAG_W-1:0] rs1,
                                 input logic [TAG_W-1:0] rs2,
                                 input logic [TAG_W-1:0] rs3);
        dec_wen_d   = wen;
        dec_rd_d    = rd;
        ecl_stall_d = stall;
        ecl_flush_e = flush;
        dec_rs1_d   = rs1;
        dec_rs2_d   = rs2;
        dec_rs3_d   = rs3;
        #2;
    endtask

    // One comparison point.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge rclk);
        @(negedge rclk);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 7'h00, 1'b0, 1'b0, 7'h00, 7'h00, 7'h00);
            nextCycle();
        end
    endtask

    initial begin
        arst_l = 1'b0;
        applyStimulus(1'b0, 7'h00, 1'b0, 1'b0, 7'h00, 7'h00, 7'h00);
        @(negedge rclk);

        // Reset state
        applyStimulus(1'b0, 7'h00, 1'b0, 1'b0, 7'h0A, 7'h00, 7'h7F);
        checkOutput("rst_rs1", 16'(byp_rs1_sel), 16'(S_RF));
        checkOutput("rst_rs3", 16'(byp_rs3_sel), 16'(S_RF));
        checkOutput("rst_wen", 16'(ecl_rf_wen_w), 16'd0);
        checkOutput("rst_rd",  16'(ecl_rf_rd_w), 16'd0);
        arst_l = 1'b1;
        idleCycles(2);

        // Back-to-back producers of 7'h0A
        applyStimulus(1'b1, 7'h0A, 1'b0, 1'b0, 7'h00, 7'h00, 7'h00);
        nextCycle();
        applyStimulus(1'b1, 7'h0A, 1'b0, 1'b0, 7'h0A, 7'h00, 7'h00);
        checkOutput("b2b_c1_e", 16'(byp_rs1_sel), 16'(S_E));
        nextCycle();
        applyStimulus(1'b0, 7'h00, 1'b0, 1'b0, 7'h0A, 7'h00, 7'h00);
        checkOutput("b2b_c2_e", 16'(byp_rs1_sel), 16'(S_E));
        nextCycle();
        applyStimulus(1'b0, 7'h00, 1'b0, 1'b0, 7'h0A, 7'h00, 7'h00);
        checkOutput("b2b_c3_m", 16'(byp_rs1_sel), 16'(S_M));
        nextCycle();
        applyStimulus(1'b0, 7'h00, 1'b0, 1'b0, 7'h0A, 7'h00, 7'h00);
        checkOutput("b2b_c4_w", 16'(byp_rs1_sel), 16'(S_W));
        nextCycle();
        applyStimulus(1'b0, 7'h00, 1'b0, 1'b0, 7'h0A, 7'h00, 7'h00);
`ifdef ECL_BYP_W2_EN
        checkOutput("b2b_c5_w2", 16'(byp_rs1_sel), 16'(S_W2));
`else
        checkOutput("b2b_c5_rf", 16'(byp_rs1_sel), 16'(S_RF));
`endif
        nextCycle();
        idleCycles(5);

        // %g0 of tid1 and cross-thread isolation
        applyStimulus(1'b1, 7'h20, 1'b0, 1'b0, 7'h00, 7'h00, 7'h00);
        nextCycle();
        applyStimulus(1'b1, 7'h05, 1'b0, 1'b0, 7'h20, 7'h45, 7'h00);
        checkOutput("g0_rs1_rf", 16'(byp_rs1_sel), 16'(S_RF));
        checkOutput("tid_pre_rf", 16'(byp_rs2_sel), 16'(S_RF));
        nextCycle();
        applyStimulus(1'b0, 7'h00, 1'b0, 1'b0, 7'h20, 7'h45, 7'h05);
        checkOutput("g0_m_rf", 16'(byp_rs1_sel), 16'(S_RF));
        checkOutput("tid_rs2_rf", 16'(byp_rs2_sel), 16'(S_RF));
        checkOutput("tid_rs3_e", 16'(byp_rs3_sel), 16'(S_E));
        nextCycle();
        idleCycles(5);

        // Flush kills the E entry of 7'h11
        applyStimulus(1'b1, 7'h11, 1'b0, 1'b0, 7'h00, 7'h00, 7'h00);
        nextCycle();
        applyStimulus(1'b0, 7'h00, 1'b0, 1'b1, 7'h00, 7'h00, 7'h11);
        checkOutput("flush_c1_e", 16'(byp_rs3_sel), 16'(S_E));
        nextCycle();
        applyStimulus(1'b0, 7'h00, 1'b0, 1'b0, 7'h00, 7'h00, 7'h11);
        checkOutput("flush_c2_rf", 16'(byp_rs3_sel), 16'(S_RF));
        nextCycle();
        applyStimulus(1'b0, 7'h00, 1'b0, 1'b0, 7'h00, 7'h00, 7'h11);
        checkOutput("flush_c3_rf", 16'(byp_rs3_sel), 16'(S_RF));
        checkOutput("flush_c3_wen", 16'(ecl_rf_wen_w), 16'd0);
        nextCycle();
        applyStimulus(1'b0, 7'h00, 1'b0, 1'b0, 7'h00, 7'h00, 7'h11);
        checkOutput("flush_c4_wen", 16'(ecl_rf_wen_w), 16'd0);
        nextCycle();
        idleCycles(5);

        // Stall (together with a flush of an empty E) bubbles 7'h12; older 7'h13 keeps moving
        applyStimulus(1'b1, 7'h13, 1'b0, 1'b0, 7'h00, 7'h00, 7'h00);
        nextCycle();
        applyStimulus(1'b0, 7'h00, 1'b0, 1'b0, 7'h00, 7'h00, 7'h00);
        nextCycle();
        applyStimulus(1'b1, 7'h12, 1'b1, 1'b1, 7'h00, 7'h13, 7'h00);
        checkOutput("stall_c2_m", 16'(byp_rs2_sel), 16'(S_M));
        nextCycle();
        applyStimulus(1'b0, 7'h00, 1'b0, 1'b0, 7'h12, 7'h13, 7'h00);
        checkOutput("stall_c3_rs1_rf", 16'(byp_rs1_sel), 16'(S_RF));
        checkOutput("stall_c3_rs2_w", 16'(byp_rs2_sel), 16'(S_W));
`ifdef ECL_BYP_W2_EN
        nextCycle();
        applyStimulus(1'b0, 7'h00, 1'b0, 1'b0, 7'h12, 7'h13, 7'h00);
`endif
        checkOutput("stall_wen", 16'(ecl_rf_wen_w), 16'd1);
        checkOutput("stall_rd",  16'(ecl_rf_rd_w), 16'h13);
        nextCycle();
        idleCycles(5);

        // Writeback latency of a single producer 7'h33
        applyStimulus(1'b1, 7'h33, 1'b0, 1'b0, 7'h00, 7'h00, 7'h00);
        nextCycle();
        for (int k = 1; k <= WLAT + 1; k++) begin
            applyStimulus(1'b0, 7'h00, 1'b0, 1'b0, 7'h00, 7'h00, 7'h00);
            if (k == WLAT) begin
                checkOutput("wb_wen_hit", 16'(ecl_rf_wen_w), 16'd1);
                checkOutput("wb_rd_hit",  16'(ecl_rf_rd_w), 16'h33);
            end else begin
                checkOutput("wb_wen_idle", 16'(ecl_rf_wen_w), 16'd0);
            end
            nextCycle();
        end
        idleCycles(5);

        // Mid-stream reset with E/M/W all valid
        applyStimulus(1'b1, 7'h21, 1'b0, 1'b0, 7'h00, 7'h00, 7'h00);
        nextCycle();
        applyStimulus(1'b1, 7'h22, 1'b0, 1'b0, 7'h00, 7'h00, 7'h00);
        nextCycle();
        applyStimulus(1'b1, 7'h23, 1'b0, 1'b0, 7'h00, 7'h00, 7'h00);
        nextCycle();
        applyStimulus(1'b0, 7'h00, 1'b0, 1'b0, 7'h23, 7'h22, 7'h21);
        checkOutput("mrst_pre_e", 16'(byp_rs1_sel), 16'(S_E));
        checkOutput("mrst_pre_m", 16'(byp_rs2_sel), 16'(S_M));
        checkOutput("mrst_pre_w", 16'(byp_rs3_sel), 16'(S_W));
`ifndef ECL_BYP_W2_EN
        checkOutput("mrst_pre_wen", 16'(ecl_rf_wen_w), 16'd1);
`endif
        arst_l = 1'b0;
        #1;
        checkOutput("mrst_rs1_rf", 16'(byp_rs1_sel), 16'(S_RF));
        checkOutput("mrst_rs2_rf", 16'(byp_rs2_sel), 16'(S_RF));
        checkOutput("mrst_rs3_rf", 16'(byp_rs3_sel), 16'(S_RF));
        checkOutput("mrst_wen", 16'(ecl_rf_wen_w), 16'd0);
        checkOutput("mrst_rd",  16'(ecl_rf_rd_w), 16'd0);
        nextCycle();
        arst_l = 1'b1;
        for (int k = 0; k < WLAT; k++) begin
            applyStimulus(1'b0, 7'h00, 1'b0, 1'b0, 7'h23, 7'h22, 7'h21);
            checkOutput("mrst_post_wen", 16'(ecl_rf_wen_w), 16'd0);
            checkOutput("mrst_post_rs3", 16'(byp_rs3_sel), 16'(S_RF));
            nextCycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Bound on total run time so the bench can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
